// File: rtl/sensor_poll_ctrl.sv
// sensor_poll_ctrl: periodic I2C register poll sequencer.
// Drives a byte-level I2C master engine over a valid/ready command channel:
// START, addr+W, pointer, RSTART, addr+R, READ(ack), READ(nack), STOP.
// Slave NACKs on address/pointer writes abort with STOP and retry up to
// MAX_RETRY times; persistent failure sets the sticky err flag.
// Build option: define POLL_TIMEOUT_EN to add a response watchdog
// (TIMEOUT_CYCLES) that abandons a stuck transaction without STOP.
module sensor_poll_ctrl #(
  parameter int unsigned PERIOD_CYCLES  = 12500000,
  parameter logic [6:0]  DEV_ADDR       = 7'h48,
  parameter logic [7:0]  REG_PTR        = 8'h00,
  parameter int unsigned MAX_RETRY      = 3
`ifdef POLL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 50000
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trig,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_op,
  output logic [7:0]  cmd_wdata,
  output logic        cmd_ack,
  input  logic        rsp_valid,
  input  logic        rsp_nack,
  input  logic [7:0]  rsp_rdata,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        busy,
  output logic        err
);

  localparam logic [2:0] OP_START  = 3'd0;
  localparam logic [2:0] OP_RSTART = 3'd1;
  localparam logic [2:0] OP_WRITE  = 3'd2;
  localparam logic [2:0] OP_READ   = 3'd3;
  localparam logic [2:0] OP_STOP   = 3'd4;

  localparam int unsigned CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ABORT_ISSUE,
    ST_ABORT_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [2:0]    cmd_op_q, cmd_op_d;
  logic [7:0]    cmd_wdata_q, cmd_wdata_d;
  logic          cmd_ack_q, cmd_ack_d;
  logic [7:0]    msb_q, msb_d;
  logic [7:0]    lsb_q, lsb_d;
  logic [15:0]   data_q, data_d;
  logic          data_valid_q, data_valid_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [3:0]    retry_q, retry_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          hs;
  logic          start_poll;
  logic          nackable_step;
  logic          retry_ok;
  logic          timeout;
  logic [2:0]    step_op;
  logic [7:0]    step_wdata;
  logic          step_ack;

  assign hs            = cmd_valid_q && cmd_ready;
  assign start_poll    = (state_q == ST_IDLE) &&
                         (trig || (cnt_q == CW'(PERIOD_CYCLES - 1)));
  assign nackable_step = (step_q == 3'd1) || (step_q == 3'd2) || (step_q == 3'd4);
  assign retry_ok      = ({28'd0, retry_q} < MAX_RETRY);

`ifdef POLL_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wd_q, wd_d;
  logic          wd_run;

  assign wd_run  = (state_q == ST_WAIT) || (state_q == ST_ABORT_WAIT) ||
                   (((state_q == ST_ISSUE) || (state_q == ST_ABORT_ISSUE)) && !cmd_ready);
  assign timeout = wd_run && (wd_q == WW'(TIMEOUT_CYCLES - 1));

  // Watchdog count: restarts whenever the sequencer moves to another step.
  always_comb begin
    wd_d = wd_q;
    if ((state_d != state_q) || (step_d != step_q)) begin
      wd_d = '0;
    end else if (wd_run) begin
      wd_d = wd_q + WW'(1);
    end
  end

  // Watchdog register.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State and output registers; reset abandons any transaction silently.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q      <= ST_IDLE;
      step_q       <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_op_q     <= '0;
      cmd_wdata_q  <= '0;
      cmd_ack_q    <= 1'b0;
      msb_q        <= '0;
      lsb_q        <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      retry_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_op_q     <= cmd_op_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_ack_q    <= cmd_ack_d;
      msb_q        <= msb_d;
      lsb_q        <= lsb_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      retry_q      <= retry_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next state: each step is ISSUE (until handshake) then WAIT (until response).
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_poll) begin
          state_d = ST_ISSUE;
          step_d  = 3'd0;
        end
      end
      ST_ISSUE: begin
        if (timeout) begin
          state_d = ST_IDLE;
        end else if (hs) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (timeout) begin
          state_d = ST_IDLE;
        end else if (rsp_valid) begin
          if (nackable_step && rsp_nack) begin
            state_d = ST_ABORT_ISSUE;
          end else if (step_q == 3'd7) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ISSUE;
            step_d  = step_q + 3'd1;
          end
        end
      end
      ST_ABORT_ISSUE: begin
        if (timeout) begin
          state_d = ST_IDLE;
        end else if (hs) begin
          state_d = ST_ABORT_WAIT;
        end
      end
      ST_ABORT_WAIT: begin
        if (timeout) begin
          state_d = ST_IDLE;
        end else if (rsp_valid) begin
          if (retry_ok) begin
            state_d = ST_ISSUE;
            step_d  = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Command contents for the step about to be issued.
  always_comb begin
    step_op    = OP_START;
    step_wdata = '0;
    step_ack   = 1'b0;
    case (step_d)
      3'd0: step_op = OP_START;
      3'd1: begin
        step_op    = OP_WRITE;
        step_wdata = {DEV_ADDR, 1'b0};
      end
      3'd2: begin
        step_op    = OP_WRITE;
        step_wdata = REG_PTR;
      end
      3'd3: step_op = OP_RSTART;
      3'd4: begin
        step_op    = OP_WRITE;
        step_wdata = {DEV_ADDR, 1'b1};
      end
      3'd5: begin
        step_op  = OP_READ;
        step_ack = 1'b1;
      end
      3'd6: begin
        step_op  = OP_READ;
        step_ack = 1'b0;
      end
      default: step_op = OP_STOP;
    endcase
  end

  // Registered outputs, poll period counter, retry bookkeeping and capture.
  always_comb begin
    cmd_valid_d  = cmd_valid_q;
    cmd_op_d     = cmd_op_q;
    cmd_wdata_d  = cmd_wdata_q;
    cmd_ack_d    = cmd_ack_q;
    msb_d        = msb_q;
    lsb_d        = lsb_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    busy_d       = busy_q;
    err_d        = err_q;
    retry_d      = retry_q;
    cnt_d        = cnt_q;

    if (hs) begin
      cmd_valid_d = 1'b0;
    end

    if (state_q == ST_IDLE) begin
      cnt_d = cnt_q + CW'(1);
      if (start_poll) begin
        cnt_d  = '0;
        busy_d = 1'b1;
      end
    end

    // Command fields are loaded only on entry to an issue state, so they stay
    // stable for however long the engine holds off cmd_ready.
    if ((state_d == ST_ISSUE) && (state_q != ST_ISSUE)) begin
      cmd_valid_d = 1'b1;
      cmd_op_d    = step_op;
      cmd_wdata_d = step_wdata;
      cmd_ack_d   = step_ack;
    end
    if ((state_d == ST_ABORT_ISSUE) && (state_q != ST_ABORT_ISSUE)) begin
      cmd_valid_d = 1'b1;
      cmd_op_d    = OP_STOP;
      cmd_wdata_d = '0;
      cmd_ack_d   = 1'b0;
    end

    if (timeout) begin
      cmd_valid_d = 1'b0;
      err_d       = 1'b1;
      retry_d     = '0;
      busy_d      = 1'b0;
    end else if (rsp_valid) begin
      if (state_q == ST_WAIT) begin
        if (step_q == 3'd5) begin
          msb_d = rsp_rdata;
        end
        if (step_q == 3'd6) begin
          lsb_d = rsp_rdata;
        end
        if (step_q == 3'd7) begin
          data_d       = {msb_q, lsb_q};
          data_valid_d = 1'b1;
          err_d        = 1'b0;
          retry_d      = '0;
          busy_d       = 1'b0;
        end
      end
      if (state_q == ST_ABORT_WAIT) begin
        if (retry_ok) begin
          retry_d = retry_q + 4'd1;
        end else begin
          err_d   = 1'b1;
          retry_d = '0;
          busy_d  = 1'b0;
        end
      end
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_op     = cmd_op_q;
  assign cmd_wdata  = cmd_wdata_q;
  assign cmd_ack    = cmd_ack_q;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_sensor_poll_ctrl.sv
// Directed bench for sensor_poll_ctrl with a zero-latency I2C engine model.
module tb_sensor_poll_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        trig = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_wdata;
  logic        cmd_ack;
  logic        rsp_valid = 1'b0;
  logic        rsp_nack = 1'b0;
  logic [7:0]  rsp_rdata = 8'h00;
  logic [15:0] data;
  logic        data_valid;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  // engine model configuration and logs
  bit         pend = 0;
  bit         pend_nack = 0;
  logic [7:0] pend_data = 8'h00;
  int         nack_s1_left = 0;
  int         nack_s4_left = 0;
  int         stall_left = 0;
  int         stall_bad = 0;
  bit         stall_active = 0;
  bit         drop_msb = 0;
  bit         inject_rsp = 0;
  logic [7:0] rd_msb = 8'h00;
  logic [7:0] rd_lsb = 8'h00;
  int         n_cmds = 0;
  int         n_start = 0;
  int         n_stop = 0;
  int         dv_count = 0;
  int         busy_cycles = 0;
  logic [2:0] log_op  [64];
  logic [7:0] log_wd  [64];
  logic       log_ack [64];

  sensor_poll_ctrl #(
    .PERIOD_CYCLES(100),
    .DEV_ADDR(7'h48),
    .REG_PTR(8'h00),
    .MAX_RETRY(3)
`ifdef POLL_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(20)
`endif
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .trig(trig),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_wdata(cmd_wdata),
    .cmd_ack(cmd_ack),
    .rsp_valid(rsp_valid),
    .rsp_nack(rsp_nack),
    .rsp_rdata(rsp_rdata),
    .data(data),
    .data_valid(data_valid),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  // Engine: accepts on handshake, answers in the following cycle.
  initial begin
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      rsp_rdata = 8'h00;
      if (data_valid === 1'b1) dv_count++;
      if (busy === 1'b1) busy_cycles++;
      if (reset_n) begin
        pend = 0;
        stall_active = 0;
        cmd_ready = 1'b1;
      end else begin
        if (pend) begin
          rsp_valid = 1'b1;
          rsp_nack  = pend_nack;
          rsp_rdata = pend_data;
          pend = 0;
        end else if (inject_rsp) begin
          rsp_valid = 1'b1;
          rsp_rdata = 8'hEE;
          inject_rsp = 0;
        end
        cmd_ready = 1'b1;
        if (!stall_active && stall_left > 0 && cmd_valid === 1'b1 &&
            cmd_op === 3'd2 && cmd_wdata === 8'h00)
          stall_active = 1;
        if (stall_active) begin
          cmd_ready = 1'b0;
          if (!(cmd_valid === 1'b1 && cmd_op === 3'd2 && cmd_wdata === 8'h00))
            stall_bad++;
          stall_left--;
          if (stall_left == 0) stall_active = 0;
        end
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
          if (n_cmds < 64) begin
            log_op[n_cmds]  = cmd_op;
            log_wd[n_cmds]  = cmd_wdata;
            log_ack[n_cmds] = cmd_ack;
          end
          n_cmds++;
          if (cmd_op == 3'd0) n_start++;
          if (cmd_op == 3'd4) n_stop++;
          pend      = 1;
          pend_nack = 0;
          pend_data = 8'h00;
          if (cmd_op == 3'd2) begin
            if (cmd_wdata == 8'h90 && nack_s1_left > 0) begin
              pend_nack = 1;
              nack_s1_left--;
            end
            if (cmd_wdata == 8'h91 && nack_s4_left > 0) begin
              pend_nack = 1;
              nack_s4_left--;
            end
          end
          if (cmd_op == 3'd3) begin
            pend_data = cmd_ack ? rd_msb : rd_lsb;
            if (cmd_ack && drop_msb) begin
              pend = 0;
              drop_msb = 0;
            end
          end
        end
      end
    end
  end

  task automatic clear_counts();
    n_cmds = 0;
    n_start = 0;
    n_stop = 0;
    dv_count = 0;
    busy_cycles = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b1;
    trig = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); end
    n_checks++; if (cmd_op !== 3'd0) begin n_fail++; $display("FAIL rst_cmd_op: got %0d want 0", cmd_op); end
    n_checks++; if (cmd_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_cmd_wdata: got %h want 00", cmd_wdata); end
    n_checks++; if (cmd_ack !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ack: got %b want 0", cmd_ack); end
    n_checks++; if (data !== 16'h0000) begin n_fail++; $display("FAIL rst_data: got %h want 0000", data); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_data_valid: got %b want 0", data_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    reset_n = 1'b0;
  endtask

  task automatic test_basic();
    logic [2:0] exp_op [8];
    int cyc;
    exp_op = '{3'd0, 3'd2, 3'd2, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4};
    apply_reset();
    clear_counts();
    rd_msb = 8'h1A;
    rd_lsb = 8'hC0;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_start: got %b want 1", busy); end
    n_checks++; if (cmd_valid !== 1'b1 || cmd_op !== 3'd0) begin n_fail++; $display("FAIL basic_first_cmd: valid=%b op=%0d want 1/0", cmd_valid, cmd_op); end
    wait_idle(200, cyc);
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_done: busy=%b want 0 within 200 cycles", busy); end
    n_checks++; if (n_cmds !== 8) begin n_fail++; $display("FAIL basic_ncmds: got %0d want 8", n_cmds); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (log_op[i] !== exp_op[i]) begin n_fail++; $display("FAIL basic_op%0d: got %0d want %0d", i, log_op[i], exp_op[i]); end
    end
    n_checks++; if (log_wd[1] !== 8'h90) begin n_fail++; $display("FAIL basic_wdata_s1: got %h want 90", log_wd[1]); end
    n_checks++; if (log_wd[2] !== 8'h00) begin n_fail++; $display("FAIL basic_wdata_s2: got %h want 00", log_wd[2]); end
    n_checks++; if (log_wd[4] !== 8'h91) begin n_fail++; $display("FAIL basic_wdata_s4: got %h want 91", log_wd[4]); end
    n_checks++; if (log_ack[5] !== 1'b1 || log_ack[6] !== 1'b0) begin n_fail++; $display("FAIL basic_read_ack: got %b%b want 10", log_ack[5], log_ack[6]); end
    n_checks++; if (data !== 16'h1AC0) begin n_fail++; $display("FAIL basic_data: got %h want 1ac0", data); end
    n_checks++; if (dv_count !== 1) begin n_fail++; $display("FAIL basic_dv_pulses: got %0d want 1", dv_count); end
    n_checks++; if (busy_cycles !== 16) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 16", busy_cycles); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", err); end
  endtask

  task automatic test_nack_retry();
    int cyc;
    apply_reset();
    clear_counts();
    nack_s1_left = 1;
    rd_msb = 8'h55;
    rd_lsb = 8'hAA;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    wait_idle(200, cyc);
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL retry_done: busy=%b want 0 within 200 cycles", busy); end
    n_checks++; if (n_cmds !== 11) begin n_fail++; $display("FAIL retry_ncmds: got %0d want 11", n_cmds); end
    n_checks++; if (log_op[2] !== 3'd4) begin n_fail++; $display("FAIL retry_abort_stop: got op %0d want 4", log_op[2]); end
    n_checks++; if (n_start !== 2 || n_stop !== 2) begin n_fail++; $display("FAIL retry_start_stop: got %0d/%0d want 2/2", n_start, n_stop); end
    n_checks++; if (data !== 16'h55AA) begin n_fail++; $display("FAIL retry_data: got %h want 55aa", data); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL retry_err: got %b want 0", err); end
    n_checks++; if (dv_count !== 1) begin n_fail++; $display("FAIL retry_dv_pulses: got %0d want 1", dv_count); end
  endtask

  task automatic test_nack_exhaust();
    int cyc;
    clear_counts();
    nack_s4_left = 100;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    wait_idle(400, cyc);
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL exh_done: busy=%b want 0 within 400 cycles", busy); end
    n_checks++; if (n_start !== 4) begin n_fail++; $display("FAIL exh_starts: got %0d want 4", n_start); end
    n_checks++; if (n_stop !== 4) begin n_fail++; $display("FAIL exh_stops: got %0d want 4", n_stop); end
    n_checks++; if (n_cmds !== 24) begin n_fail++; $display("FAIL exh_ncmds: got %0d want 24", n_cmds); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL exh_err: got %b want 1", err); end
    n_checks++; if (data !== 16'h55AA) begin n_fail++; $display("FAIL exh_data_kept: got %h want 55aa", data); end
    n_checks++; if (dv_count !== 0) begin n_fail++; $display("FAIL exh_no_dv: got %0d want 0", dv_count); end
    // a later clean poll clears the sticky error
    nack_s4_left = 0;
    clear_counts();
    rd_msb = 8'h12;
    rd_lsb = 8'h34;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    wait_idle(200, cyc);
    repeat (2) @(negedge clk);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL exh_err_clear: got %b want 0", err); end
    n_checks++; if (data !== 16'h1234) begin n_fail++; $display("FAIL exh_recover_data: got %h want 1234", data); end
  endtask

  task automatic test_stall();
    int cyc;
    int ptr_writes;
    apply_reset();
    clear_counts();
    stall_left = 10;
    stall_bad = 0;
    rd_msb = 8'hBE;
    rd_lsb = 8'hEF;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    wait_idle(200, cyc);
    repeat (2) @(negedge clk);
    ptr_writes = 0;
    for (int i = 0; i < 8; i++)
      if (log_op[i] == 3'd2 && log_wd[i] == 8'h00) ptr_writes++;
    n_checks++; if (stall_left !== 0) begin n_fail++; $display("FAIL stall_applied: remaining %0d want 0", stall_left); end
    n_checks++; if (stall_bad !== 0) begin n_fail++; $display("FAIL stall_stable: %0d unstable cycles want 0", stall_bad); end
    n_checks++; if (ptr_writes !== 1) begin n_fail++; $display("FAIL stall_one_accept: got %0d want 1", ptr_writes); end
    n_checks++; if (n_cmds !== 8) begin n_fail++; $display("FAIL stall_ncmds: got %0d want 8", n_cmds); end
    n_checks++; if (busy_cycles !== 26) begin n_fail++; $display("FAIL stall_busy_cycles: got %0d want 26", busy_cycles); end
    n_checks++; if (data !== 16'hBEEF) begin n_fail++; $display("FAIL stall_data: got %h want beef", data); end
  endtask

  task automatic test_period();
    int k;
    int cyc;
    int s0;
    apply_reset();
    clear_counts();
    k = 0;
    while (busy !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    n_checks++; if (k !== 100) begin n_fail++; $display("FAIL period_first: started after %0d cycles want 100", k); end
    wait_idle(200, cyc);
    k = 0;
    while (busy !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    n_checks++; if (k !== 100) begin n_fail++; $display("FAIL period_gap: started after %0d idle cycles want 100", k); end
    // trig while busy must be dropped
    repeat (4) @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    wait_idle(200, cyc);
    s0 = n_start;
    k = 0;
    while (busy !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    n_checks++; if (k !== 100) begin n_fail++; $display("FAIL period_busy_trig: started after %0d idle cycles want 100", k); end
    wait_idle(200, cyc);
    // trig in the same cycle as period expiry
    s0 = n_start;
    for (int i = 1; i < 100; i++) @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL period_coincide_start: busy=%b want 1", busy); end
    wait_idle(200, cyc);
    n_checks++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL period_coincide_once: got %0d starts want 1", n_start - s0); end
    k = 0;
    while (busy !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    n_checks++; if (k !== 100) begin n_fail++; $display("FAIL period_after_coincide: started after %0d idle cycles want 100", k); end
    wait_idle(200, cyc);
  endtask

  task automatic test_reset_mid();
    int k;
    int stops;
    apply_reset();
    clear_counts();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    k = 0;
    while (!(cmd_valid === 1'b1 && cmd_op === 3'd1) && k < 50) begin @(negedge clk); k++; end
    n_checks++; if (cmd_op !== 3'd1) begin n_fail++; $display("FAIL midrst_reach_s3: op=%0d want 1 within 50 cycles", cmd_op); end
    stops = n_stop;
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (cmd_valid !== 1'b0 || cmd_op !== 3'd0 || cmd_wdata !== 8'h00 || cmd_ack !== 1'b0) begin
      n_fail++; $display("FAIL midrst_cmd: valid=%b op=%0d wdata=%h ack=%b want 0/0/00/0", cmd_valid, cmd_op, cmd_wdata, cmd_ack);
    end
    n_checks++; if (busy !== 1'b0 || err !== 1'b0 || data_valid !== 1'b0 || data !== 16'h0000) begin
      n_fail++; $display("FAIL midrst_status: busy=%b err=%b dv=%b data=%h want 0/0/0/0000", busy, err, data_valid, data);
    end
    @(negedge clk);
    n_checks++; if (n_stop !== stops) begin n_fail++; $display("FAIL midrst_no_stop: got %0d stops want %0d", n_stop, stops); end
    reset_n = 1'b0;
  endtask

`ifdef POLL_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    apply_reset();
    clear_counts();
    drop_msb = 1;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    k = 0;
    while (!(cmd_valid === 1'b1 && cmd_op === 3'd3 && cmd_ack === 1'b1) && k < 50) begin @(negedge clk); k++; end
    k = 0;
    do begin @(negedge clk); k++; end while (busy === 1'b1 && k < 100);
    n_checks++; if (k !== 20) begin n_fail++; $display("FAIL tmo_latency: idle after %0d cycles want 20", k); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b want 1", err); end
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_cmd_valid: got %b want 0", cmd_valid); end
    inject_rsp = 1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL tmo_late_rsp: busy=%b err=%b want 0/1", busy, err); end
    n_checks++; if (dv_count !== 0 || data !== 16'h0000) begin n_fail++; $display("FAIL tmo_no_data: dv=%0d data=%h want 0/0000", dv_count, data); end
    n_checks++; if (n_stop !== 0) begin n_fail++; $display("FAIL tmo_no_stop: got %0d stops want 0", n_stop); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_nack_retry();
    test_nack_exhaust();
    test_stall();
    test_period();
    test_reset_mid();
`ifdef POLL_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, got timeout want completion");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/sensor_poll_ctrl.md
Name: sensor_poll_ctrl

Overview:
Sequencer that periodically reads a 16-bit register from an I2C sensor through a byte-level I2C master engine and presents the result to the 7-segment display path.
- Issues START / address / pointer / repeated-START / two-byte read / STOP commands one at a time over a valid/ready command channel.
- Retries on slave NACK and flags persistent failure.
- Sits between the I2C byte engine and SEGMENT_DISPLAY, replacing free-running I2C polling.

Parameters:
PERIOD_CYCLES, 12500000, clk cycles between poll starts (250 ms at 50 MHz)
DEV_ADDR, 7'h48, 7-bit slave address
REG_PTR, 8'h00, register pointer written before the read
MAX_RETRY, 3, extra attempts after a NACKed attempt (0..15)
TIMEOUT_CYCLES, 50000, response watchdog limit (only with macro)

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  synchronous reset, active-high (asserted = 1); port name kept per codebase convention
trig  in  1  request an immediate poll; honoured only in IDLE
cmd_valid  out  1  command to engine valid
cmd_ready  in  1  engine accepts command
cmd_op  out  3  0=START, 1=RSTART, 2=WRITE, 3=READ, 4=STOP
cmd_wdata  out  8  byte for WRITE
cmd_ack  out  1  for READ: 1 = master ACKs, 0 = master NACKs
rsp_valid  in  1  one-cycle pulse, one per accepted command
rsp_nack  in  1  slave NACKed a WRITE; qualified by rsp_valid
rsp_rdata  in  8  READ byte; qualified by rsp_valid
data  out  16  last good reading {MSB,LSB}
data_valid  out  1  one-cycle pulse when data updates
busy  out  1  transaction in progress
err  out  1  sticky failure flag; cleared by next successful poll

Behaviour:
- Reset values: cmd_valid=0, cmd_op=0, cmd_wdata=0, cmd_ack=0, data=16'h0000, data_valid=0, busy=0, err=0. Period counter=0, retry count=0, state=IDLE.
- Reset mid-transaction: return to IDLE next edge with no STOP issued. The engine shares the reset.
- IDLE: period counter increments each cycle.
  - Poll starts when counter==PERIOD_CYCLES-1 or trig=1. Both in the same cycle start one poll.
  - On start: counter:=0, busy:=1.
  - Counter frozen while busy. trig ignored while busy.
- Step sequence, each as ISSUE then WAIT:
  - S0 START
  - S1 WRITE {DEV_ADDR,0}
  - S2 WRITE REG_PTR
  - S3 RSTART
  - S4 WRITE {DEV_ADDR,1}
  - S5 READ ack=1 (MSB)
  - S6 READ ack=0 (LSB)
  - S7 STOP
- ISSUE: cmd_valid=1 with stable op/wdata/ack until cmd_valid&&cmd_ready; cmd_valid drops the cycle after the handshake. WAIT: hold until rsp_valid.
- rsp_valid during ISSUE, or with no outstanding command, is ignored.
- Registered outputs; next ISSUE asserts the cycle after rsp_valid. Minimum poll: 16 cycles with zero-latency engine.
- S5/S6 capture rsp_rdata into MSB/LSB holding registers. rsp_nack is ignored on READ, START, RSTART and STOP.
- NACK on S1, S2 or S4 (rsp_nack=1 with rsp_valid):
  - Go to ABORT: issue STOP, wait for its response.
  - If retry_cnt<MAX_RETRY: retry_cnt++, restart at S0 immediately.
  - Otherwise: err:=1, retry_cnt:=0, busy:=0, IDLE. data unchanged, no data_valid.
- Success, on S7 response:
  - data:={MSB,LSB}, data_valid=1 for exactly one cycle.
  - err:=0, retry_cnt:=0, busy:=0, return to IDLE.
- Total attempts per poll: MAX_RETRY+1.

Optional Feature:
POLL_TIMEOUT_EN
- Defined: a watchdog counts cycles in every WAIT and in ISSUE-with-cmd_ready=0, cleared on each step change.
  - Reaching TIMEOUT_CYCLES: err:=1, retry_cnt:=0, cmd_valid:=0, busy:=0, IDLE, with no STOP and no retry.
  - A late rsp_valid after timeout is ignored.
- Undefined: no watchdog logic; the controller waits indefinitely.

Test Plan:
- Zero-latency engine, trig pulse, READ returns 8'h1A then 8'hC0 -> commands in S0..S7 order with wdata 8'h90, 8'h00, 8'h91; data=16'h1AC0; single data_valid pulse; busy low after S7 response.
- Slave NACKs S1 on first attempt only -> STOP issued, then full sequence repeats; data updated; err=0.
- S4 NACK on every attempt, MAX_RETRY=3 -> exactly 4 START and 4 STOP commands; err=1; data retains previous value; no data_valid.
- cmd_ready held low 10 cycles during S2 -> cmd_valid, cmd_op=2 and cmd_wdata=8'h00 stable throughout; exactly one command accepted.
- PERIOD_CYCLES=100, no trig -> polls start every 100 idle cycles. trig during busy -> no extra poll. trig together with period expiry -> one poll.
- With POLL_TIMEOUT_EN and TIMEOUT_CYCLES=20, rsp_valid withheld after S5 -> err=1 and busy=0 after 20 cycles; later rsp_valid has no effect. Reset asserted mid-S3 -> all outputs at reset values next edge.
